// File: rtl/sme_rng_bank.sv
// sme_rng_bank
// Masking-randomness source for the SME datapath. RMAX independent xorshift32
// lanes are seeded one word at a time from an entropy port. Once every lane
// is seeded, all lanes are presented in parallel on rng. Each adv pulse steps
// every lane at once.
//
// Optional feature macro: SME_RNG_AUTORESEED_EN
//   defined   -> a 16-bit advance counter raises reseed_req every
//                RESEED_INTERVAL advances.
//   undefined -> no counter is built and reseed_req is tied low.

module sme_rng_bank #(
    parameter int XLEN            = 32,
    parameter int SMAX            = 4,
    parameter int RESEED_INTERVAL = 65535,
    localparam int RMAX           = SMAX + (SMAX * (SMAX - 1)) / 2
) (
    input  logic            g_clk,
    input  logic            g_reset,
    output logic            g_clk_req,
    input  logic            seed_valid,
    output logic            seed_ready,
    input  logic [XLEN-1:0] seed_data,
    input  logic            reseed,
    input  logic            adv,
    output logic            rng_valid,
    output logic [XLEN-1:0] rng [0:RMAX-1],
    output logic            reseed_req
);

    localparam int          IDX_W     = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [31:0] ZERO_SUBST = 32'h9E37_79B9;

    typedef enum logic [0:0] {
        ST_SEED = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One xorshift32 step, each shift truncated to 32 bits.
    function automatic logic [31:0] xs32_step(input logic [31:0] x);
        logic [31:0] t;
        t = x;
        t = t ^ (t << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    // An all-zero xorshift state never leaves zero. Substitute a fixed
    // non-zero constant for a zero seed.
    function automatic logic [31:0] seed_fix(input logic [31:0] w);
        logic [31:0] r;
        if (w == 32'h0000_0000) begin
            r = ZERO_SUBST;
        end else begin
            r = w;
        end
        return r;
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [IDX_W-1:0]       idx_r;
    logic [IDX_W-1:0]       idx_nxt_s;
    logic [XLEN-1:0]        lane_r [0:RMAX-1];

    logic                   seed_acc_s;
    logic                   lane_load_s;
    logic                   lane_step_s;
    logic                   lane_clear_s;

    // The handshake depends only on registered state, so the entropy source
    // never sees a combinational loop through seed_ready.
    assign seed_ready = (state_r == ST_SEED);
    assign rng_valid  = (state_r == ST_RUN);
    assign seed_acc_s = seed_valid && seed_ready;

    // The clock must run while seeding, and while the consumer wants a step.
    assign g_clk_req  = (state_r == ST_SEED) || adv;

    // Compute the next state and seed index, and select the lane update.
    // reseed always beats a seed accept or an advance.
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r;
        lane_load_s  = 1'b0;
        lane_step_s  = 1'b0;
        lane_clear_s = 1'b0;
        case (state_r)
            ST_SEED: begin
                if (reseed) begin
                    state_nxt_s  = ST_SEED;
                    idx_nxt_s    = {IDX_W{1'b0}};
                    lane_clear_s = 1'b1;
                end else if (seed_acc_s) begin
                    lane_load_s = 1'b1;
                    if (idx_r == IDX_W'(RMAX - 1)) begin
                        state_nxt_s = ST_RUN;
                        idx_nxt_s   = {IDX_W{1'b0}};
                    end else begin
                        state_nxt_s = ST_SEED;
                        idx_nxt_s   = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_nxt_s = ST_SEED;
                    idx_nxt_s   = idx_r;
                end
            end
            ST_RUN: begin
                if (reseed) begin
                    state_nxt_s  = ST_SEED;
                    idx_nxt_s    = {IDX_W{1'b0}};
                    lane_clear_s = 1'b1;
                end else if (adv) begin
                    state_nxt_s = ST_RUN;
                    lane_step_s = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s  = ST_SEED;
                idx_nxt_s    = {IDX_W{1'b0}};
                lane_clear_s = 1'b1;
            end
        endcase
    end

    // State register and seed index.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_r <= ST_SEED;
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Lane storage: clear, load the indexed lane with a seed, or step all lanes.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            for (int k = 0; k < RMAX; k++) begin
                lane_r[k] <= {XLEN{1'b0}};
            end
        end else begin
            for (int k = 0; k < RMAX; k++) begin
                if (lane_clear_s) begin
                    lane_r[k] <= {XLEN{1'b0}};
                end else if (lane_load_s && (idx_r == IDX_W'(k))) begin
                    lane_r[k] <= seed_fix(seed_data);
                end else if (lane_step_s) begin
                    lane_r[k] <= xs32_step(lane_r[k]);
                end else begin
                    lane_r[k] <= lane_r[k];
                end
            end
        end
    end

    // Hide partial seed material: lanes are only visible once fully seeded.
    always_comb begin
        for (int k = 0; k < RMAX; k++) begin
            if (state_r == ST_RUN) begin
                rng[k] = lane_r[k];
            end else begin
                rng[k] = {XLEN{1'b0}};
            end
        end
    end

`ifdef SME_RNG_AUTORESEED_EN
    logic [15:0] adv_cnt_r;
    logic        reseed_req_r;
    logic        adv_eff_s;

    assign adv_eff_s  = lane_step_s;
    assign reseed_req = reseed_req_r;

    // Count effective advances. Raise a sticky reseed request every
    // RESEED_INTERVAL advances. Only reseed or reset clears the request.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            adv_cnt_r    <= 16'd0;
            reseed_req_r <= 1'b0;
        end else if (reseed) begin
            adv_cnt_r    <= 16'd0;
            reseed_req_r <= 1'b0;
        end else if (adv_eff_s) begin
            if ((adv_cnt_r + 16'd1) == 16'(RESEED_INTERVAL)) begin
                adv_cnt_r    <= 16'd0;
                reseed_req_r <= 1'b1;
            end else begin
                adv_cnt_r    <= adv_cnt_r + 16'd1;
                reseed_req_r <= reseed_req_r;
            end
        end else begin
            adv_cnt_r    <= adv_cnt_r;
            reseed_req_r <= reseed_req_r;
        end
    end
`else
    assign reseed_req = 1'b0;
`endif

endmodule

// File: tb/tb_sme_rng_bank.sv
// Self-checking bench for sme_rng_bank. Expected lane words are pushed to a
// scoreboard queue when stimulus is driven. They are popped and compared once
// the DUT presents the output.
module tb_sme_rng_bank;

    localparam int NL = 10;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        g_clk_req;
    logic        seed_valid;
    logic        seed_ready;
    logic [31:0] seed_data;
    logic        reseed;
    logic        adv;
    logic        rng_valid;
    logic [31:0] rng [0:NL-1];
    logic        reseed_req;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [NL];
    logic [31:0] exp_q [$];

    sme_rng_bank #(.XLEN(32), .SMAX(4), .RESEED_INTERVAL(4)) dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .g_clk_req  (g_clk_req),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed_data  (seed_data),
        .reseed     (reseed),
        .adv        (adv),
        .rng_valid  (rng_valid),
        .rng        (rng),
        .reseed_req (reseed_req)
    );

    always #5 g_clk = ~g_clk;

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic push_model();
        for (int k = 0; k < NL; k++) exp_q.push_back(model[k]);
    endtask

    task automatic step_model();
        for (int k = 0; k < NL; k++) model[k] = xs(model[k]);
    endtask

    // Seed all lanes back-to-back. Word i is base+i, or 0 at zero_lane.
    // Each cycle also checks that the handshake is open and no output leaks.
    task automatic feed(input logic [31:0] base, input int zero_lane);
        logic [31:0] w;
        for (int i = 0; i < NL; i++) begin
            w = (i == zero_lane) ? 32'h0 : base + 32'(i);
            seed_valid = 1'b1;
            seed_data  = w;
            total++;
            if (seed_ready !== 1'b1 || rng_valid !== 1'b0) begin
                bad++;
                $display("FAIL seed_hs[%0d]: ready=%b valid=%b want ready=1 valid=0", i, seed_ready, rng_valid);
            end
            model[i] = (w == 32'h0) ? 32'h9E3779B9 : w;
            tick();
        end
        seed_valid = 1'b0;
        seed_data  = 32'h0;
    endtask

    task automatic test_reset();
        g_reset = 1'b1; seed_valid = 1'b0; seed_data = 32'h0; reseed = 1'b0; adv = 1'b0;
        tick(); tick();
        total++;
        if (rng_valid !== 1'b0 || seed_ready !== 1'b1 || reseed_req !== 1'b0 || g_clk_req !== 1'b1) begin
            bad++;
            $display("FAIL reset_ctl: valid=%b ready=%b req=%b clkreq=%b want 0 1 0 1", rng_valid, seed_ready, reseed_req, g_clk_req);
        end
        for (int k = 0; k < NL; k++) begin
            total++;
            if (rng[k] !== 32'h0) begin
                bad++;
                $display("FAIL reset_rng[%0d]: got %h want 0", k, rng[k]);
            end
        end
        g_reset = 1'b0;
        tick();
    endtask

    task automatic test_seed_seq();
        logic [31:0] e;
        feed(32'd1, -1);
        push_model();
        total++;
        if (rng_valid !== 1'b1 || g_clk_req !== 1'b0) begin
            bad++;
            $display("FAIL seed_done: valid=%b clkreq=%b want 1 0", rng_valid, g_clk_req);
        end
        for (int k = 0; k < NL; k++) begin
            e = exp_q.pop_front();
            total++;
            if (rng[k] !== e || rng[k] !== 32'(k + 1)) begin
                bad++;
                $display("FAIL seed_rng[%0d]: got %h want %h", k, rng[k], e);
            end
        end
    endtask

    task automatic test_advance();
        logic [31:0] e;
        adv = 1'b1;
        #1;
        total++;
        if (g_clk_req !== 1'b1) begin
            bad++;
            $display("FAIL clkreq_adv: got %b want 1", g_clk_req);
        end
        step_model(); push_model();
        tick();
        adv = 1'b0;
        total++;
        if (rng[0] !== 32'h00042021 || rng[1] !== 32'h00084042) begin
            bad++;
            $display("FAIL adv_const: got %h %h want 00042021 00084042", rng[0], rng[1]);
        end
        for (int k = 0; k < NL; k++) begin
            e = exp_q.pop_front();
            total++;
            if (rng[k] !== e) begin
                bad++;
                $display("FAIL adv1_rng[%0d]: got %h want %h", k, rng[k], e);
            end
        end
        // Hold: no adv for 5 cycles, values unchanged.
        for (int c = 0; c < 5; c++) begin
            push_model();
            tick();
            for (int k = 0; k < NL; k++) begin
                e = exp_q.pop_front();
                total++;
                if (rng[k] !== e) begin
                    bad++;
                    $display("FAIL hold_rng[%0d] c%0d: got %h want %h", k, c, rng[k], e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        adv = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step_model(); push_model();
            tick();
            for (int k = 0; k < NL; k++) begin
                e = exp_q.pop_front();
                total++;
                if (rng[k] !== e) begin
                    bad++;
                    $display("FAIL b2b_rng[%0d] c%0d: got %h want %h", k, c, rng[k], e);
                end
            end
        end
        adv = 1'b0;
    endtask

    task automatic test_zero_seed();
        reseed = 1'b1; tick(); reseed = 1'b0;
        feed(32'h11, 3);
        total++;
        if (rng_valid !== 1'b1 || rng[3] !== 32'h9E3779B9 || rng[4] !== 32'h15) begin
            bad++;
            $display("FAIL zero_seed: valid=%b rng3=%h rng4=%h want 1 9e3779b9 00000015", rng_valid, rng[3], rng[4]);
        end
    endtask

    task automatic test_reseed_adv();
        logic [31:0] e;
        reseed = 1'b1; adv = 1'b1;
        tick();
        reseed = 1'b0; adv = 1'b0;
        total++;
        if (rng_valid !== 1'b0 || seed_ready !== 1'b1) begin
            bad++;
            $display("FAIL reseed_ctl: valid=%b ready=%b want 0 1", rng_valid, seed_ready);
        end
        for (int k = 0; k < NL; k++) begin
            total++;
            if (rng[k] !== 32'h0) begin
                bad++;
                $display("FAIL reseed_rng[%0d]: got %h want 0", k, rng[k]);
            end
        end
        feed(32'h500, -1);
        push_model();
        for (int k = 0; k < NL; k++) begin
            e = exp_q.pop_front();
            total++;
            if (rng[k] !== e) begin
                bad++;
                $display("FAIL reseed_seed[%0d]: got %h want %h", k, rng[k], e);
            end
        end
    endtask

    task automatic test_reset_midseed();
        logic [31:0] e;
        reseed = 1'b1; tick(); reseed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seed_valid = 1'b1; seed_data = 32'hDEAD0000 + 32'(i);
            tick();
        end
        seed_valid = 1'b0;
        g_reset = 1'b1; tick(); g_reset = 1'b0;
        feed(32'h700, -1);
        push_model();
        total++;
        if (rng_valid !== 1'b1 || rng[0] !== 32'h700) begin
            bad++;
            $display("FAIL midseed: valid=%b rng0=%h want 1 00000700", rng_valid, rng[0]);
        end
        for (int k = 0; k < NL; k++) begin
            e = exp_q.pop_front();
            total++;
            if (rng[k] !== e) begin
                bad++;
                $display("FAIL midseed_rng[%0d]: got %h want %h", k, rng[k], e);
            end
        end
    endtask

    task automatic test_autoreseed();
        logic exp_req;
        reseed = 1'b1; tick(); reseed = 1'b0;
        feed(32'h900, -1);
        for (int c = 1; c <= 6; c++) begin
            adv = 1'b1;
            tick();
`ifdef SME_RNG_AUTORESEED_EN
            exp_req = (c >= 4);
`else
            exp_req = 1'b0;
`endif
            total++;
            if (reseed_req !== exp_req) begin
                bad++;
                $display("FAIL reseed_req adv%0d: got %b want %b", c, reseed_req, exp_req);
            end
        end
        adv = 1'b0;
        reseed = 1'b1; tick(); reseed = 1'b0;
        total++;
        if (reseed_req !== 1'b0) begin
            bad++;
            $display("FAIL reseed_req_clr: got %b want 0", reseed_req);
        end
    endtask

    initial begin
        test_reset();
        test_seed_seq();
        test_advance();
        test_back_to_back();
        test_zero_seed();
        test_reseed_adv();
        test_reset_midseed();
        test_autoreseed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
